rc_ladder_iir: RTL and testbench
================================

# rc_ladder_iir

Cycle-based digital model of a cascaded RC low-pass ladder: `N_STAGES` first-order sections, each computing y += (x − y)·2^−SHIFT, with per-channel state for `CHANNELS` time-multiplexed channels. It replaces fixed single-section RC subcircuits in the digital co-simulation path with one block generalised in channel count, ladder depth, data width and pole position. It adds valid/ready streaming and synchronous state clear. It sits between the sample source and any downstream probe or converter model.

## Interface
- `DATA_W`, 16: signed sample width.
- `CHANNELS`, 4: number of independent channels (≥1).
- `N_STAGES`, 3: number of cascaded sections (≥1).
- `SHIFT`, 4: pole coefficient, alpha = 2^−SHIFT (1..DATA_W−1).
- `clk` in 1: sole clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: input sample present.
- `in_ready` out 1: block can accept this cycle.
- `in_ch` in CH_W: channel tag; CH_W = max(1, clog2(CHANNELS)).
- `in_data` in DATA_W: signed sample.
- `out_valid` out 1: output sample present.
- `out_ready` in 1: downstream accepts.
- `out_ch` out CH_W: channel tag of output.
- `out_data` out DATA_W: signed filtered sample.
- `clear` in 1: synchronous zero of all filter state.
- `stage_bypass` in N_STAGES: per-stage bypass. Present only with `RC_LADDER_BYPASS_EN`.

## Operation
- State array: `s[stage][ch]`, signed, DATA_W+SHIFT bits, holding y scaled by 2^SHIFT.
- Section update when its pipeline slot advances:
  - d = (x <<< SHIFT) − s, computed at DATA_W+SHIFT+1 bits.
  - s' = s + (d >>> SHIFT), arithmetic shift.
  - y = s' >>> SHIFT, which truncates toward −inf.
  - No overflow is possible, because s' lies between s and x·2^SHIFT.
- Stage k takes its x from stage k−1's y. Stage 0 takes x from `in_data`.
- Read-modify-write of `s[k][ch]` happens within stage k's cycle. Back-to-back samples on the same channel therefore see the updated state; no hazard logic is needed.
- Stall: stall = `out_valid` && !`out_ready`. The whole pipeline freezes, no state updates, and `in_ready` = !stall.
- A sample with `in_ch` ≥ CHANNELS is accepted and discarded. It updates no state and produces no output.
- `clear`:
  - Zeroes all state and invalidates all pipeline slots on the next edge.
  - `in_ready` is 0 in any cycle where `clear` is 1.
  - Clear has priority over stall and over an input handshake in the same cycle.
- Reset (`rst_n`=0 at edge) has the same effect as `clear`, plus:
  - `out_valid`=0, `out_ch`=0, `out_data`=0.
  - `in_ready`=0 while reset is asserted; `in_ready`=1 on the first cycle after reset.

## Timing
- Latency: an input accepted at edge t appears with `out_valid` after edge t+N_STAGES−1, i.e. N_STAGES registered slots counting the accepting edge.
- Throughput: one sample per cycle when unstalled.
- Outputs hold stable while `out_valid` && !`out_ready`.
- Reset or clear asserted mid-stream drops all in-flight samples. No partial output is emitted.

## Configuration
- Macro: `RC_LADDER_BYPASS_EN`.
- Defined:
  - The `stage_bypass` port exists.
  - A bypassed stage outputs y = x, and its channel state is loaded with x <<< SHIFT, so un-bypassing is glitch-free.
  - Bypass is sampled per slot as the slot advances.
- Undefined: no port, and all stages always filter.

## Structure
- `rc_ladder_pkg`: CH_W and state-width helper functions, plus shared localparams.
- Sub-module `rc_ladder_stage`:
  - One section with its own channel state array, valid/ch/data slot register, stall and clear inputs.
  - Instantiated N_STAGES times in a generate loop.

## Test plan
- N_STAGES=1, SHIFT=4, ch0 step of 1600 held → `out_data` sequence 100, 193, 281, …; converges to 1600 within 1 LSB.
- Default parameters, alternating samples ch0=+1000 and ch1=−1000 → each channel's output matches an independent reference model; no cross-talk.
- Same-channel back-to-back input plus `out_ready` low for 5 cycles → outputs unchanged during the stall; the final sequence equals the unstalled run.
- `clear` pulsed mid-stream with 3 samples in flight → those samples are never output; the next step restarts from zero state (first output 100 for N_STAGES=1).
- `in_ch`=5 with CHANNELS=4 → accepted (`in_ready` 1), no `out_valid`, channel states unchanged.
- With `RC_LADDER_BYPASS_EN` and all stages bypassed: input 1234 → output 1234 after N_STAGES cycles. Release bypass with input held → output stays 1234.

Source files
------------

// File: rtl/rc_ladder_pkg.sv
// rc_ladder_pkg: shared sizing helpers and default parameters for the RC ladder IIR.
package rc_ladder_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_N_STAGES = 3;
    localparam int DEF_SHIFT    = 4;

    // Channel tag width; a single channel still gets a 1-bit tag.
    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // State holds y scaled by 2^shift, so it needs shift extra bits.
    function automatic int st_w(input int data_w, input int shift);
        return data_w + shift;
    endfunction

endpackage

// File: rtl/rc_ladder_stage.sv
// rc_ladder_stage: one first-order RC section, y += (x - y) * 2^-SHIFT, with its own
// per-channel state array and one pipeline slot (valid/ch/y).
module rc_ladder_stage
    import rc_ladder_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int CH_W     = ch_w(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     advance,
    input  logic                     bypass,
    input  logic                     in_vld,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_x,
    output logic                     out_vld,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_y
);

    localparam int SW = st_w(DATA_W, SHIFT);

    logic signed [SW-1:0]     s_q [CHANNELS];
    logic signed [SW-1:0]     s_d [CHANNELS];
    logic                     vld_q, vld_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic signed [DATA_W-1:0] y_q, y_d;

    logic signed [SW-1:0]     s_cur, s_new;
    logic signed [SW:0]       x_sc, d, d_sh, s_sum;
    logic                     sum_msb_unused;

    // Fetch the state of the channel currently in this stage's input slot.
    always_comb begin
        s_cur = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (in_ch == CH_W'(c)) s_cur = s_q[c];
    end

    // Section arithmetic at SW+1 bits; s' stays between s and x*2^SHIFT so SW bits suffice.
    always_comb begin
        x_sc  = {in_x[DATA_W-1], in_x, {SHIFT{1'b0}}};
        d     = x_sc - {s_cur[SW-1], s_cur};
        d_sh  = d >>> SHIFT;
        s_sum = {s_cur[SW-1], s_cur} + d_sh;
        s_new = bypass ? x_sc[SW-1:0] : s_sum[SW-1:0];
    end

    assign sum_msb_unused = s_sum[SW];

    // Next slot/state: clear wins, otherwise read-modify-write on advance.
    always_comb begin
        vld_d = vld_q;
        ch_d  = ch_q;
        y_d   = y_q;
        for (int c = 0; c < CHANNELS; c++) s_d[c] = s_q[c];
        if (clear) begin
            vld_d = 1'b0;
            for (int c = 0; c < CHANNELS; c++) s_d[c] = '0;
        end else if (advance) begin
            vld_d = in_vld;
            ch_d  = in_ch;
            y_d   = s_new[SW-1:SHIFT];
            if (in_vld)
                for (int c = 0; c < CHANNELS; c++)
                    if (in_ch == CH_W'(c)) s_d[c] = s_new;
        end
    end

    // Slot and state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            ch_q  <= '0;
            y_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) s_q[c] <= '0;
        end else begin
            vld_q <= vld_d;
            ch_q  <= ch_d;
            y_q   <= y_d;
            for (int c = 0; c < CHANNELS; c++) s_q[c] <= s_d[c];
        end
    end

    assign out_vld = vld_q;
    assign out_ch  = ch_q;
    assign out_y   = y_q;

endmodule

// File: rtl/rc_ladder_iir.sv
// rc_ladder_iir: N_STAGES cascaded RC sections, CHANNELS time-multiplexed channels,
// valid/ready streaming with whole-pipeline stall and synchronous clear.
// Optional macro RC_LADDER_BYPASS_EN adds the per-stage stage_bypass port.
module rc_ladder_iir
    import rc_ladder_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int N_STAGES = DEF_N_STAGES,
    parameter int SHIFT    = DEF_SHIFT,
    localparam int CH_W    = ch_w(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     clear
`ifdef RC_LADDER_BYPASS_EN
   ,input  logic [N_STAGES-1:0]      stage_bypass
`endif
);

    // Index 0 is the block input; index k+1 is stage k's slot.
    logic [N_STAGES:0]             vld_c;
    logic [N_STAGES:0][CH_W-1:0]   ch_c;
    logic [N_STAGES:0][DATA_W-1:0] x_c;
    logic [N_STAGES-1:0]           byp;
    logic                          stall;

`ifdef RC_LADDER_BYPASS_EN
    assign byp = stage_bypass;
`else
    assign byp = '0;
`endif

    // A full output slot that downstream refuses freezes every stage.
    assign stall    = out_valid && !out_ready;
    assign in_ready = rst_n && !clear && !stall;

    // Out-of-range channel tags are consumed but enter the pipe as a bubble.
    assign vld_c[0] = in_valid && in_ready && ({1'b0, in_ch} < (CH_W+1)'(CHANNELS));
    assign ch_c[0]  = in_ch;
    assign x_c[0]   = in_data;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        rc_ladder_stage #(
            .DATA_W   (DATA_W),
            .CHANNELS (CHANNELS),
            .SHIFT    (SHIFT),
            .CH_W     (CH_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear),
            .advance (!stall),
            .bypass  (byp[k]),
            .in_vld  (vld_c[k]),
            .in_ch   (ch_c[k]),
            .in_x    (x_c[k]),
            .out_vld (vld_c[k+1]),
            .out_ch  (ch_c[k+1]),
            .out_y   (x_c[k+1])
        );
    end

    assign out_valid = vld_c[N_STAGES];
    assign out_ch    = ch_c[N_STAGES];
    assign out_data  = x_c[N_STAGES];

endmodule

// File: tb/tb_rc_ladder_iir.sv
// tb_rc_ladder_iir: scoreboard bench for rc_ladder_iir. Two instances: "a" uses the
// default parameters, "b" is a single-section ladder with 5 channels (3-bit tag).
module tb_rc_ladder_iir;

    localparam int SH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_clear = 0;
    logic [1:0]         a_in_ch = '0, a_out_ch;
    logic signed [15:0] a_in_data = '0, a_out_data;
    logic [2:0]         a_byp = '0;

    logic               b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_clear = 0;
    logic [2:0]         b_in_ch = '0, b_out_ch;
    logic signed [15:0] b_in_data = '0, b_out_data;
    logic [0:0]         b_byp = '0;

    rc_ladder_iir dut (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ch(a_in_ch), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_ch(a_out_ch), .out_data(a_out_data), .clear(a_clear)
`ifdef RC_LADDER_BYPASS_EN
       ,.stage_bypass(a_byp)
`endif
    );

    rc_ladder_iir #(.N_STAGES(1), .CHANNELS(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ch(b_in_ch), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_ch(b_out_ch), .out_data(b_out_data), .clear(b_clear)
`ifdef RC_LADDER_BYPASS_EN
       ,.stage_bypass(b_byp)
`endif
    );

    typedef struct { int ch; int data; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int   bcap[$];
    int   vec = 0;
    int   err = 0;
    longint ma [3][4];
    longint mb [5];

    function automatic longint fdiv(input longint a, input longint b);
        longint q = a / b;
        if ((a % b) != 0 && a < 0) q--;
        return q;
    endfunction

    // Reference section: state scaled by 16, floor semantics throughout.
    function automatic longint sec(input longint x, inout longint s, input bit byp);
        if (byp) s = x * (1 << SH);
        else     s = s + fdiv(x * (1 << SH) - s, 1 << SH);
        return fdiv(s, 1 << SH);
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        vec++;
        if (act != req) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic send_a(input int ch, input int x);
        int n = 0;
        exp_t e;
        longint v = x;
        a_in_valid = 1; a_in_ch = 2'(ch); a_in_data = 16'(x);
        @(negedge clk);
        while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
        chk("a_accept", a_in_ready, 1);
        if (a_in_ready) begin
            for (int k = 0; k < 3; k++) v = sec(v, ma[k][ch], a_byp[k]);
            e.ch = ch; e.data = int'(v);
            qa.push_back(e);
        end
        @(posedge clk); #1;
        a_in_valid = 0;
    endtask

    task automatic send_b(input int ch, input int x);
        int n = 0;
        exp_t e;
        b_in_valid = 1; b_in_ch = 3'(ch); b_in_data = 16'(x);
        @(negedge clk);
        while (!b_in_ready && n < 100) begin @(negedge clk); n++; end
        chk("b_accept", b_in_ready, 1);
        if (b_in_ready && ch < 5) begin
            e.ch = ch; e.data = int'(sec(x, mb[ch], b_byp[0]));
            qb.push_back(e);
        end
        @(posedge clk); #1;
        b_in_valid = 0;
    endtask

    // Monitor a: compare presented output to the queue head each cycle; pop on handshake.
    always @(negedge clk) begin
        if (a_out_valid) begin
            if (qa.size() == 0) begin
                vec++; err++;
                $display("FAIL a_unexpected: got ch %0d data %0d expected no output", a_out_ch, a_out_data);
            end else begin
                chk("a_ch", a_out_ch, qa[0].ch);
                chk("a_data", a_out_data, qa[0].data);
                if (a_out_ready) void'(qa.pop_front());
            end
        end
    end

    // Monitor b: same, plus a capture of every consumed sample.
    always @(negedge clk) begin
        if (b_out_valid) begin
            if (qb.size() == 0) begin
                vec++; err++;
                $display("FAIL b_unexpected: got ch %0d data %0d expected no output", b_out_ch, b_out_data);
            end else begin
                chk("b_ch", b_out_ch, qb[0].ch);
                chk("b_data", b_out_data, qb[0].data);
                if (b_out_ready) begin
                    bcap.push_back(int'(b_out_data));
                    void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_a_ch", a_out_ch, 0);
        chk("rst_a_ready", a_in_ready, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_ready", b_in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_a_ready", a_in_ready, 1);
        chk("post_rst_b_ready", b_in_ready, 1);
        @(posedge clk); #1;

        // Step of 1600 into a single section.
        for (int i = 0; i < 200; i++) send_b(0, 1600);
        repeat (3) @(posedge clk); #1;
        chk("b_step0", bcap[0], 100);
        chk("b_step1", bcap[1], 193);
        chk("b_step2", bcap[2], 281);
        chk("b_step_conv", (bcap[199] >= 1599 && bcap[199] <= 1600), 1);
        bcap.delete();

        // Clear, then the step restarts from zero.
        b_clear = 1;
        @(negedge clk);
        chk("b_clear_ready", b_in_ready, 0);
        @(posedge clk); #1;
        b_clear = 0;
        for (int c = 0; c < 5; c++) mb[c] = 0;
        for (int i = 0; i < 3; i++) send_b(0, 1600);
        repeat (2) @(posedge clk); #1;
        chk("b_restart0", bcap[0], 100);
        chk("b_restart1", bcap[1], 193);
        chk("b_restart2", bcap[2], 281);

        // Out-of-range tags: consumed, no output, no state change (next ch0 output is 364).
        send_b(5, 777);
        @(negedge clk);
        chk("b_oor_no_valid", b_out_valid, 0);
        @(posedge clk); #1;
        send_b(7, -500);
        send_b(0, 1600);
        repeat (2) @(posedge clk); #1;
        chk("b_oor_state_kept", bcap[3], 364);

        // Alternating opposite-sign channels through the full ladder.
        for (int i = 0; i < 10; i++) begin
            send_a(0, 1000);
            send_a(1, -1000);
        end

        // Back-to-back same channel with a 5-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 6; i++) send_a(2, 300 * (i + 1));
            end
            begin
                repeat (3) @(posedge clk); #1;
                a_out_ready = 0;
                repeat (5) @(posedge clk); #1;
                a_out_ready = 1;
            end
        join
        repeat (6) @(posedge clk); #1;

        // Fill all three slots under stall, then clear: none of them may come out.
        a_out_ready = 0;
        for (int i = 0; i < 3; i++) send_a(3, 500);
        @(negedge clk);
        chk("a_full_valid", a_out_valid, 1);
        chk("a_full_stall_ready", a_in_ready, 0);
        @(posedge clk); #1;
        a_clear = 1;
        @(negedge clk);
        chk("a_clear_ready", a_in_ready, 0);
        @(posedge clk); #1;
        a_clear = 0;
        qa.delete();
        for (int k = 0; k < 3; k++) for (int c = 0; c < 4; c++) ma[k][c] = 0;
        a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("a_flushed", a_out_valid, 0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send_a(0, 1600);

`ifdef RC_LADDER_BYPASS_EN
        repeat (5) @(posedge clk); #1;
        a_byp = '1;
        for (int i = 0; i < 4; i++) send_a(3, 1234);
        repeat (5) @(posedge clk); #1;
        a_byp = '0;
        for (int i = 0; i < 4; i++) send_a(3, 1234);
`endif

        n = 0;
        while ((qa.size() + qb.size()) != 0 && n < 50) begin @(posedge clk); n++; end
        #1;
        chk("drain_left", qa.size() + qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
